// File: rtl/ctrl_bus_owner_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_bus_owner_arb_pkg
// Description : Shared types for the SCL/SDA bus-ownership arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_bus_owner_arb_pkg;

    // Which controller engine currently owns the physical SCL/SDA pair
    typedef enum logic {
        OwnerActive  = 1'b0,
        OwnerStandby = 1'b1
    } bus_owner_e;

    // Handoff sequencer states
    typedef enum logic [1:0] {
        OWN       = 2'd0,
        DRAIN     = 2'd1,
        WAIT_FREE = 2'd2,
        SWITCH    = 2'd3
    } arb_state_e;

endpackage : ctrl_bus_owner_arb_pkg
`default_nettype wire

// File: rtl/ctrl_bus_owner_arb_bus_free_detector.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_bus_owner_arb_bus_free_detector
// Description : Counts consecutive cycles with SCL and SDA both high and flags
//               the cycle in which the count reaches the bus-free threshold.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_bus_owner_arb_bus_free_detector #(
    parameter int IDLE_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      bus_scl_i,
    input  logic                      bus_sda_i,
    input  logic [IDLE_CNT_WIDTH-1:0] t_idle_i,
    output logic                      bus_free_o
);

    localparam logic [IDLE_CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [IDLE_CNT_WIDTH-1:0] idle_q;
    logic [IDLE_CNT_WIDTH-1:0] idle_d;
    logic [IDLE_CNT_WIDTH-1:0] w_thresh;

    // Next idle count (saturating) and threshold compare; a zero threshold acts as one
    always_comb begin
        w_thresh = (t_idle_i == '0) ? IDLE_CNT_WIDTH'(1) : t_idle_i;
        if (bus_scl_i && bus_sda_i) begin
            idle_d = (idle_q == c_cnt_max) ? idle_q : idle_q + 1'b1;
        end else begin
            idle_d = '0;
        end
        bus_free_o = !clear_i && (idle_d >= w_thresh);
    end

    // Idle counter register; held at zero whenever the sequencer is not waiting
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule : ctrl_bus_owner_arb_bus_free_detector
`default_nettype wire

// File: rtl/ctrl_bus_owner_arb.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_bus_owner_arb
// Description : Arbitrates the single SCL/SDA pad pair between the active and
//               standby controller engines with a sequenced, drain-first
//               ownership handoff and an optional abort timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_bus_owner_arb
    import ctrl_bus_owner_arb_pkg::*;
#(
    parameter int IDLE_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      handoff_req_i,
    input  logic                      handoff_tgt_i,
    input  logic                      act_scl_i,
    input  logic                      act_sda_i,
    input  logic                      sby_scl_i,
    input  logic                      sby_sda_i,
    input  logic                      act_busy_i,
    input  logic                      sby_busy_i,
    input  logic                      bus_scl_i,
    input  logic                      bus_sda_i,
    input  logic [IDLE_CNT_WIDTH-1:0] t_idle_i,
    input  logic [IDLE_CNT_WIDTH-1:0] t_timeout_i,
    output logic                      bus_scl_o,
    output logic                      bus_sda_o,
    output logic                      act_en_o,
    output logic                      sby_en_o,
    output logic                      owner_o,
    output logic                      handoff_busy_o,
    output logic                      handoff_done_o,
    output logic                      handoff_err_o
);

    localparam logic [IDLE_CNT_WIDTH-1:0] c_cnt_max = '1;

    arb_state_e                state_q, state_d;
    bus_owner_e                owner_q, owner_d;
    bus_owner_e                tgt_q, tgt_d;
    logic                      act_en_q, act_en_d;
    logic                      sby_en_q, sby_en_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      scl_q, scl_d;
    logic                      sda_q, sda_d;
    logic [IDLE_CNT_WIDTH-1:0] to_q, to_d;

    logic                      w_bus_free;
    logic                      w_old_busy;
    logic                      w_to_hit;
    logic [IDLE_CNT_WIDTH-1:0] w_to_inc;

    ctrl_bus_owner_arb_bus_free_detector #(
        .IDLE_CNT_WIDTH (IDLE_CNT_WIDTH)
    ) u_bus_free (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (state_q != WAIT_FREE),
        .bus_scl_i  (bus_scl_i),
        .bus_sda_i  (bus_sda_i),
        .t_idle_i   (t_idle_i),
        .bus_free_o (w_bus_free)
    );

    // Handoff sequencer next-state: drain old owner, wait for idle bus, one released cycle
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        tgt_d      = tgt_q;
        act_en_d   = act_en_q;
        sby_en_d   = sby_en_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        to_d       = '0;
        w_old_busy = (owner_q == OwnerStandby) ? sby_busy_i : act_busy_i;
        w_to_inc   = (to_q == c_cnt_max) ? to_q : to_q + 1'b1;
        w_to_hit   = (t_timeout_i != '0) && (w_to_inc >= t_timeout_i);

        case (state_q)
            OWN: begin
                if (handoff_req_i) begin
                    if (bus_owner_e'(handoff_tgt_i) == owner_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = bus_owner_e'(handoff_tgt_i);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                to_d = w_to_inc;
                // Timeout beats a same-cycle end of the old owner's transfer
                if (w_to_hit) begin
                    err_d    = 1'b1;
                    state_d  = OWN;
                    act_en_d = (owner_q == OwnerActive);
                    sby_en_d = (owner_q == OwnerStandby);
                end else if (!w_old_busy) begin
                    act_en_d = 1'b0;
                    sby_en_d = 1'b0;
                    state_d  = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                to_d = w_to_inc;
                // Reaching the bus-free threshold beats a same-cycle timeout
                if (w_bus_free) begin
                    state_d = SWITCH;
                end else if (w_to_hit) begin
                    err_d    = 1'b1;
                    state_d  = OWN;
                    act_en_d = (owner_q == OwnerActive);
                    sby_en_d = (owner_q == OwnerStandby);
                end
            end
            SWITCH: begin
                owner_d  = tgt_q;
                act_en_d = (tgt_q == OwnerActive);
                sby_en_d = (tgt_q == OwnerStandby);
                done_d   = 1'b1;
                state_d  = OWN;
            end
            default: begin
                state_d = OWN;
            end
        endcase
    end

    // Pad drive: released in SWITCH, otherwise the owner's drive only while it is enabled
    always_comb begin
        if (state_q == SWITCH) begin
            scl_d = 1'b1;
            sda_d = 1'b1;
        end else if (owner_q == OwnerStandby) begin
            scl_d = sby_en_q ? sby_scl_i : 1'b1;
            sda_d = sby_en_q ? sby_sda_i : 1'b1;
        end else begin
            scl_d = act_en_q ? act_scl_i : 1'b1;
            sda_d = act_en_q ? act_sda_i : 1'b1;
        end
    end

    // State, ownership, pulse and pad registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= OWN;
            owner_q  <= OwnerActive;
            tgt_q    <= OwnerActive;
            act_en_q <= 1'b1;
            sby_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            tgt_q    <= tgt_d;
            act_en_q <= act_en_d;
            sby_en_q <= sby_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            to_q     <= to_d;
        end
    end

    assign bus_scl_o      = scl_q;
    assign bus_sda_o      = sda_q;
    assign act_en_o       = act_en_q;
    assign sby_en_o       = sby_en_q;
    assign owner_o        = owner_q;
    assign handoff_busy_o = (state_q != OWN);
    assign handoff_done_o = done_q;
    assign handoff_err_o  = err_q;

endmodule : ctrl_bus_owner_arb
`default_nettype wire

// File: tb/tb_ctrl_bus_owner_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_bus_owner_arb
// Description : Self-checking bench for ctrl_bus_owner_arb: table-driven drive
//               forwarding checks plus handoff, timeout and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_bus_owner_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, tgt;
    logic        act_scl, act_sda, sby_scl, sby_sda;
    logic        act_busy, sby_busy;
    logic        bscl, bsda;
    logic [15:0] t_idle, t_to;
    logic        o_scl, o_sda, act_en, sby_en, owner, hbusy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Output packing: {scl, sda, act_en, sby_en, owner, busy, done, err}
    typedef struct {
        string      name;
        logic       req, tgt, ascl, asda, sscl, ssda;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] expq[$];
    string      nameq[$];

    ctrl_bus_owner_arb #(.IDLE_CNT_WIDTH(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .handoff_req_i  (req),
        .handoff_tgt_i  (tgt),
        .act_scl_i      (act_scl),
        .act_sda_i      (act_sda),
        .sby_scl_i      (sby_scl),
        .sby_sda_i      (sby_sda),
        .act_busy_i     (act_busy),
        .sby_busy_i     (sby_busy),
        .bus_scl_i      (bscl),
        .bus_sda_i      (bsda),
        .t_idle_i       (t_idle),
        .t_timeout_i    (t_to),
        .bus_scl_o      (o_scl),
        .bus_sda_o      (o_sda),
        .act_en_o       (act_en),
        .sby_en_o       (sby_en),
        .owner_o        (owner),
        .handoff_busy_o (hbusy),
        .handoff_done_o (done),
        .handoff_err_o  (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {o_scl, o_sda, act_en, sby_en, owner, hbusy, done, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
        end
    endtask

    // Request a handoff to t; the old owner stays busy for edges 0..busy_len-1,
    // bus SDA is low at edge low_at. Returns the edge index of the done/err pulse
    // and the edge index at which the old owner's enable first read low.
    task automatic handoff(input logic t, input int busy_len, input int low_at,
                           output int n, output int fall, output logic gd, output logic ge);
        req = 1'b1;
        tgt = t;
        if (t) act_busy = (busy_len > 0); else sby_busy = (busy_len > 0);
        step();
        req  = 1'b0;
        n    = 0;
        fall = -1;
        gd   = done;
        ge   = err;
        while (!gd && !ge && n < 200) begin
            if (t) act_busy = (n + 1 < busy_len); else sby_busy = (n + 1 < busy_len);
            bsda = (n + 1 != low_at);
            step();
            n++;
            if (fall < 0 && (t ? !act_en : !sby_en)) fall = n;
            gd = done;
            ge = err;
        end
        act_busy = 1'b0;
        sby_busy = 1'b0;
        bsda     = 1'b1;
    endtask

    initial begin
        int   n, fall, cnt;
        logic gd, ge, quiet;

        tbl[0] = '{"fwd_act_scl_lo",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0110_0000};
        tbl[1] = '{"fwd_act_sda_lo",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1010_0000};
        tbl[2] = '{"sby_ignored",     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1110_0000};
        tbl[3] = '{"fwd_act_both_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0010_0000};
        tbl[4] = '{"same_owner_req",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1110_0010};
        tbl[5] = '{"done_one_shot",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1110_0000};

        rst = 1'b1; req = 1'b0; tgt = 1'b0;
        act_scl = 1'b1; act_sda = 1'b1; sby_scl = 1'b1; sby_sda = 1'b1;
        act_busy = 1'b0; sby_busy = 1'b0; bscl = 1'b1; bsda = 1'b1;
        t_idle = 16'd5; t_to = 16'd0;
        repeat (3) step();
        chk("reset_state", outs(), 8'b1110_0000);
        rst = 1'b0;

        // Drive forwarding and same-owner request, via scoreboard queue
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; tgt = tbl[i].tgt;
            act_scl = tbl[i].ascl; act_sda = tbl[i].asda;
            sby_scl = tbl[i].sscl; sby_sda = tbl[i].ssda;
            expq.push_back(tbl[i].exp);
            nameq.push_back(tbl[i].name);
            step();
            chk(nameq.pop_front(), outs(), expq.pop_front());
        end
        req = 1'b0;

        // Handoff active -> standby, active busy 10 cycles, t_idle=5
        act_scl = 1'b0; act_sda = 1'b1; sby_scl = 1'b0; sby_sda = 1'b0;
        handoff(1'b1, 10, -1, n, fall, gd, ge);
        chk("h1_done_edge", n, 16);
        chk("h1_en_fall_edge", fall, 10);
        chk("h1_pulses", {gd, ge}, 2'b10);
        chk("h1_after", outs(), 8'b1101_1010);
        step();
        chk("h1_sby_fwd", outs(), 8'b0001_1000);

        // Handoff standby -> active with SDA glitch restarting the idle count
        sby_scl = 1'b1; sby_sda = 1'b1; act_scl = 1'b1; act_sda = 1'b1;
        handoff(1'b0, 10, 13, n, fall, gd, ge);
        chk("h2_done_edge", n, 19);
        chk("h2_en_fall_edge", fall, 10);
        chk("h2_state", {owner, act_en, sby_en, gd, ge}, 5'b01010);

        // Timeout with old owner stuck busy
        t_to = 16'd20;
        handoff(1'b1, 1000, -1, n, fall, gd, ge);
        chk("to_err_edge", n, 20);
        chk("to_state", {owner, act_en, sby_en, hbusy, gd, ge}, 6'b010001);
        step();
        chk("to_err_one_shot", err, 1'b0);

        // Busy drops on the same edge the timeout fires: timeout wins
        handoff(1'b1, 20, -1, n, fall, gd, ge);
        chk("to_vs_busy_edge", n, 20);
        chk("to_vs_busy_state", {owner, act_en, sby_en, gd, ge}, 5'b01001);

        // Bus-free threshold and timeout on the same edge: SWITCH wins
        t_to = 16'd15;
        handoff(1'b1, 10, -1, n, fall, gd, ge);
        chk("free_vs_to_edge", n, 16);
        chk("free_vs_to_state", {owner, act_en, sby_en, gd, ge}, 5'b10110);

        // Same-owner request (owner standby) gives done next cycle
        t_to = 16'd0; t_idle = 16'd0;
        req = 1'b1; tgt = 1'b1;
        step();
        req = 1'b0;
        chk("same_owner_sby", {done, hbusy, owner}, 3'b101);

        // Requests while busy are ignored; t_idle=0 needs one free cycle
        req = 1'b1; tgt = 1'b0;
        step();
        chk("ign_busy_set", hbusy, 1'b1);
        tgt = 1'b1;
        step();
        chk("ign_no_done_e1", done, 1'b0);
        tgt = 1'b0; bscl = 1'b0;
        step();
        chk("ign_no_done_e2", done, 1'b0);
        req = 1'b0; bscl = 1'b1;
        cnt = 2;
        while (!done && cnt < 50) begin
            step();
            cnt++;
        end
        chk("idle0_done_edge", cnt, 4);
        chk("idle0_owner", {owner, act_en, sby_en}, 3'b010);
        step();
        chk("idle0_no_extra", {done, hbusy}, 2'b00);

        // Reset in WAIT_FREE returns to reset values with no pulses
        t_idle = 16'd50;
        req = 1'b1; tgt = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        chk("rst_pre_wait", {hbusy, act_en}, 2'b10);
        rst = 1'b1;
        step();
        chk("rst_mid_handoff", outs(), 8'b1110_0000);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (60) begin
            step();
            if (done || err || hbusy) quiet = 1'b0;
        end
        chk("rst_quiet_after", quiet, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ctrl_bus_owner_arb
`default_nettype wire
